imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension unit for the 16-bit datapath, succeeding the fixed 8-to-16 zero extender.
- Accepts an IN_W-bit immediate plus a 2-bit mode and a tag.
- Produces an OUT_W-bit value using zero-extend, sign-extend, branch-offset (sign-extend, shift left 1) or upper-load placement.
- Sits between decode and the ALU operand mux.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops an immediate and in_ready is a registered signal.

---
 rtl/imm_ext_pkg.sv | 19 +
 rtl/imm_ext_core.sv | 43 ++++
 rtl/imm_extend_pipe.sv | 112 +++++++++++
 tb/tb_imm_extend_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
// Shared definitions for the pipelined immediate-extension unit:
//   - extension mode codes carried on in_mode
//   - skid-buffer occupancy state encodings
package imm_ext_pkg;

  localparam logic [1:0] EXT_ZERO  = 2'd0;  // {0s, imm}
  localparam logic [1:0] EXT_SIGN  = 2'd1;  // {sign copies, imm}
  localparam logic [1:0] EXT_BOFS  = 2'd2;  // sign-extend, then << 1
  localparam logic [1:0] EXT_UPPER = 2'd3;  // {imm, 0s}

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
// Purely combinational immediate extender.
// Ports:
//   in_imm  [IN_W-1:0]  immediate to extend
//   in_mode [1:0]       extension mode (EXT_* codes)
//   ext     [OUT_W-1:0] extended value
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] bofs;
  logic [OUT_W-1:0] upper;

  assign zext  = {{PAD_W{1'b0}}, in_imm};
  assign sext  = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
  // Branch offsets are halfword-scaled: shift the sign-extended value left
  // by one, discarding the top bit.
  assign bofs  = {sext[OUT_W-2:0], 1'b0};
  assign upper = {in_imm, {PAD_W{1'b0}}};

  always_comb begin
    ext = zext;
    case (in_mode)
      EXT_ZERO:  ext = zext;
      EXT_SIGN:  ext = sext;
      EXT_BOFS:  ext = bofs;
      EXT_UPPER: ext = upper;
      default:   ext = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Pipelined immediate-extension stage with valid/ready handshakes and a
// two-entry skid buffer. The immediate is extended on the input side; only
// the extended value and its tag are stored.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake (in_ready decoded from state)
//   in_imm, in_mode, in_tag    immediate, extension mode, sideband tag
//   out_valid / out_ready      output handshake (out_valid decoded from state)
//   out_data, out_tag          extended value and tag of the head beat
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (OUT_W < IN_W + 1) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W must be at least IN_W+1");
    end
  endgenerate

  logic [OUT_W-1:0] ext;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .ext     (ext)
  );

  skid_state_t      state;
  logic [OUT_W-1:0] main_data;
  logic [TAG_W-1:0] main_tag;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;

  logic in_xfer;
  logic out_xfer;

  // Both handshake outputs are pure decodes of the state register, so
  // neither out_ready nor any other input reaches them combinationally.
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  assign out_tag   = main_tag;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_tag  <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_data <= ext;
            main_tag  <= in_tag;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_xfer, out_xfer})
            2'b10: begin
              // Head is stalled: park the newcomer behind it.
              skid_data <= ext;
              skid_tag  <= in_tag;
              state     <= ST_TWO;
            end
            2'b01: state <= ST_EMPTY;
            2'b11: begin
              // Head leaves as the newcomer arrives: no bubble.
              main_data <= ext;
              main_tag  <= in_tag;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          if (out_xfer) begin
            main_data <= skid_data;
            main_tag  <= skid_tag;
            state     <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default-parameter instance (8 -> 16).
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_imm = '0;
  logic [1:0]  in_mode = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  // Wide-immediate instance (12 -> 16).
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [11:0] in_imm2 = '0;
  logic [1:0]  in_mode2 = '0;
  logic [3:0]  in_tag2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [15:0] out_data2;
  logic [3:0]  out_tag2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(16), .TAG_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_imm(in_imm2), .in_mode(in_mode2), .in_tag(in_tag2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_tag(out_tag2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference extension from arithmetic on the numeric value.
  function automatic logic [15:0] ref_ext(input int unsigned imm, input int unsigned mode,
                                          input int in_w, input int out_w);
    longint unsigned m, s;
    m = 64'd1 << out_w;
    s = (imm >= (32'd1 << (in_w - 1))) ? imm + m - (64'd1 << in_w) : imm;
    case (mode)
      0: return 16'(imm);
      1: return 16'(s);
      2: return 16'((s * 2) % m);
      default: return 16'((longint'(imm) << (out_w - in_w)) % m);
    endcase
  endfunction

  typedef struct {
    logic [7:0]  imm;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [11:0] imm;
    logic [1:0]  mode;
    logic [15:0] exp;
  } vec12_t;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  t;
  } beat_t;

  beat_t exp_q[$];
  int    accepted  = 0;
  int    delivered = 0;

  // One streaming cycle: score the transfers that will happen at the next
  // edge, then advance. Inputs must already be set.
  task automatic monitor_cycle();
    beat_t b;
    logic  in_fire, out_fire;
    check("occ_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("occ_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("stream_spurious_beat", 32'(1), 32'(0));
      end else begin
        b = exp_q.pop_front();
        check("stream_data", 32'(out_data), 32'(b.d));
        check("stream_tag", 32'(out_tag), 32'(b.t));
        delivered++;
        $display("beat tag=%0d data=0x%04h expected=0x%04h", out_tag, out_data, b.d);
      end
    end
    if (in_fire) begin
      b.d = ref_ext(in_imm, in_mode, 8, 16);
      b.t = in_tag;
      exp_q.push_back(b);
      accepted++;
    end
    step();
  endtask

  vec_t   vecs[8];
  vec12_t vecs12[4];

  initial begin
    vecs[0] = '{8'h73, 2'd0, 16'h0073};
    vecs[1] = '{8'hFF, 2'd0, 16'h00FF};
    vecs[2] = '{8'hFF, 2'd0, 16'h00FF};
    vecs[3] = '{8'hFF, 2'd1, 16'hFFFF};
    vecs[4] = '{8'hFF, 2'd2, 16'hFFFE};
    vecs[5] = '{8'hFF, 2'd3, 16'hFF00};
    vecs[6] = '{8'h80, 2'd2, 16'hFF00};
    vecs[7] = '{8'h80, 2'd1, 16'hFF80};
    vecs12[0] = '{12'h800, 2'd1, 16'hF800};
    vecs12[1] = '{12'h800, 2'd2, 16'hF000};
    vecs12[2] = '{12'h800, 2'd3, 16'h8000};
    vecs12[3] = '{12'h800, 2'd0, 16'h0800};

    // ---- reset values ----
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_tag", 32'(out_tag), 32'(0));
    // Inputs offered during reset must be ignored.
    in_valid = 1'b1; in_imm = 8'h55; in_tag = 4'd9;
    step();
    step();
    check("rst_ignore_in", 32'(out_valid), 32'(0));
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("post_rst_empty", 32'(out_valid), 32'(0));

    // ---- table: back-to-back beats, each visible one cycle after accept ----
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_imm   = vecs[i].imm;
      in_mode  = vecs[i].mode;
      in_tag   = 4'(i + 1);
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(1));
      step();
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(1));
      check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
      check($sformatf("tbl%0d_tag", i), 32'(out_tag), 32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    check("tbl_drained", 32'(out_valid), 32'(0));

    // ---- 12-bit instance parameter sweep ----
    for (int i = 0; i < 4; i++) begin
      in_valid2 = 1'b1;
      in_imm2   = vecs12[i].imm;
      in_mode2  = vecs12[i].mode;
      in_tag2   = 4'(i + 4);
      step();
      check($sformatf("w12_%0d_valid", i), 32'(out_valid2), 32'(1));
      check($sformatf("w12_%0d_data", i), 32'(out_data2), 32'(vecs12[i].exp));
      check($sformatf("w12_%0d_tag", i), 32'(out_tag2), 32'(i + 4));
    end
    in_valid2 = 1'b0;
    step();

    // ---- back-pressure: three beats offered while consumer stalls ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd0; in_imm = 8'h11; in_tag = 4'd1;
    step();
    check("bp_t1_in_ready", 32'(in_ready), 32'(1));
    check("bp_t1_tag", 32'(out_tag), 32'(1));
    in_imm = 8'h22; in_tag = 4'd2;
    step();
    check("bp_full_in_ready", 32'(in_ready), 32'(0));
    check("bp_full_tag", 32'(out_tag), 32'(1));
    in_imm = 8'h33; in_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_in_ready", 32'(in_ready), 32'(0));
      check("bp_hold_tag", 32'(out_tag), 32'(1));
      check("bp_hold_data", 32'(out_data), 32'(16'h0011));
    end
    // in_ready must not react within the cycle to out_ready.
    out_ready = 1'b1;
    #1;
    check("bp_no_comb_path", 32'(in_ready), 32'(0));
    step();
    check("bp_rel_tag2", 32'(out_tag), 32'(2));
    check("bp_rel_data2", 32'(out_data), 32'(16'h0022));
    check("bp_rel_in_ready", 32'(in_ready), 32'(1));
    step();
    check("bp_rel_tag3", 32'(out_tag), 32'(3));
    check("bp_rel_data3", 32'(out_data), 32'(16'h0033));
    in_valid = 1'b0;
    step();
    check("bp_drained", 32'(out_valid), 32'(0));

    // ---- reset while holding two beats ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 8'hA5; in_tag = 4'd7;
    step();
    in_tag = 4'd8;
    step();
    check("rst2_full", 32'(in_ready), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    check("rst2_out_valid", 32'(out_valid), 32'(0));
    check("rst2_out_data", 32'(out_data), 32'(0));
    check("rst2_in_ready", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst2_no_stale", 32'(out_valid), 32'(0));
    end

    // ---- randomized streaming, out_ready toggling every cycle ----
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // A beat stays offered until it is taken.
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(3) != 0);
        in_imm   = 8'($urandom_range(255));
        in_mode  = 2'($urandom_range(3));
        in_tag   = 4'(accepted);
      end
      if (cyc >= 200) out_ready = ~out_ready;
      else out_ready = ($urandom_range(1) == 1);
      monitor_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) monitor_cycle();
    check("stream_drained", 32'(exp_q.size()), 32'(0));
    check("stream_count", 32'(delivered), 32'(accepted));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
